// File: rtl/uart_event_bridge.sv
// uart_event_bridge
//   Byte-stream front end between a UART (rx/tx byte strobes) and the DVS
//   gesture accelerator.
//   - Parses 5-byte event packets (X_HI, X_LO, Y_HI, Y_LO, POL) into a
//     first-word-fall-through valid/ready event stream with a capture
//     timestamp.
//   - Queues classifier results and sends each one as a 2-byte message.
//   - Serves host commands: FF echo, FE status, FD config, FC soft reset,
//     FB stats. Command bytes are only recognised at a packet boundary.
//   - Resyncs to a packet boundary after BYTE_TIMEOUT idle cycles
//     mid-packet, and keeps saturating drop and error counters.
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   rx_data, rx_valid     received byte and its 1-cycle strobe
//   tx_data, tx_valid     byte to transmit and its 1-cycle strobe
//   tx_busy               transmitter busy; no byte is issued while high
//   evt_valid, evt_ready  event stream handshake
//   evt_x, evt_y, evt_pol, evt_ts   head event fields
//   gest_valid, gest_class, gest_conf  classifier result strobe and data
//   acc_state             accelerator debug state, reported by status
//   soft_rst              1-cycle soft-reset pulse to the accelerator
module uart_event_bridge #(
  parameter int unsigned COORD_W      = 9,
  parameter int unsigned TS_W         = 16,
  parameter int unsigned EVT_DEPTH    = 8,
  parameter int unsigned RESP_DEPTH   = 4,
  parameter int unsigned CLASS_W      = 2,
  parameter int unsigned CONF_W       = 4,
  parameter int unsigned BYTE_TIMEOUT = 4096,
  parameter logic [7:0]  CFG0         = 8'd20,
  parameter logic [7:0]  CFG1         = 8'd8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [7:0]         rx_data,
  input  logic               rx_valid,
  output logic [7:0]         tx_data,
  output logic               tx_valid,
  input  logic               tx_busy,
  output logic               evt_valid,
  input  logic               evt_ready,
  output logic [COORD_W-1:0] evt_x,
  output logic [COORD_W-1:0] evt_y,
  output logic               evt_pol,
  output logic [TS_W-1:0]    evt_ts,
  input  logic               gest_valid,
  input  logic [CLASS_W-1:0] gest_class,
  input  logic [CONF_W-1:0]  gest_conf,
  input  logic [2:0]         acc_state,
  output logic               soft_rst
);

  localparam int unsigned HI_W  = COORD_W - 8;
  localparam int unsigned EVT_W = 2 * COORD_W + 1 + TS_W;
  localparam int unsigned RES_W = CLASS_W + CONF_W;
  localparam int unsigned EA    = $clog2(EVT_DEPTH);
  localparam int unsigned RA    = $clog2(RESP_DEPTH);
  localparam int unsigned EL_W  = EA + 1;
  localparam int unsigned RL_W  = RA + 1;
  localparam int unsigned TO_W  = $clog2(BYTE_TIMEOUT) + 1;

  typedef enum logic [2:0] {P_XH, P_XL, P_YH, P_YL, P_POL} p_state_t;
  typedef enum logic [2:0] {T_IDLE, T_B0, T_GAP0, T_B1, T_GAP1} t_state_t;
  typedef enum logic [2:0] {M_ECHO, M_STATUS, M_CONFIG, M_STATS, M_RESULT} msg_t;

  function automatic msg_t decode_cmd(input logic [7:0] b);
    unique case (b)
      8'hFF:   return M_ECHO;
      8'hFE:   return M_STATUS;
      8'hFD:   return M_CONFIG;
      default: return M_STATS;
    endcase
  endfunction

  function automatic logic [7:0] sat_add(input logic [7:0] a, input logic [1:0] inc);
    logic [8:0] s;
    s = {1'b0, a} + {7'b0, inc};
    return s[8] ? 8'hFF : s[7:0];
  endfunction

  // ---------------------------------------------------------------- parser
  p_state_t          p_state, p_next;
  logic [HI_W-1:0]   x_hi, y_hi;
  logic [7:0]        x_lo, y_lo;
  logic [TO_W-1:0]   idle_cnt;
  logic [TS_W-1:0]   ts;
  logic              cmd_byte, cmd_fc, timeout, evt_push_req;

  assign cmd_byte = rx_valid && (p_state == P_XH) && (rx_data >= 8'hFB);
  // Soft reset acts on the edge that samples FC; every block treats it as a flush.
  assign cmd_fc   = cmd_byte && (rx_data == 8'hFC);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) p_state <= P_XH;
    else        p_state <= p_next;
  end

  always_comb begin
    p_next       = p_state;
    timeout      = 1'b0;
    evt_push_req = 1'b0;
    if (rx_valid) begin
      unique case (p_state)
        P_XH:    if (!cmd_byte) p_next = P_XL;
        P_XL:    p_next = P_YH;
        P_YH:    p_next = P_YL;
        P_YL:    p_next = P_POL;
        P_POL: begin
          p_next       = P_XH;
          evt_push_req = 1'b1;
        end
        default: p_next = P_XH;
      endcase
    end else if (p_state != P_XH && idle_cnt == TO_W'(BYTE_TIMEOUT - 1)) begin
      p_next  = P_XH;
      timeout = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_hi <= '0;
      x_lo <= '0;
      y_hi <= '0;
      y_lo <= '0;
    end else if (rx_valid && !cmd_byte) begin
      unique case (p_state)
        P_XH:    x_hi <= rx_data[HI_W-1:0];
        P_XL:    x_lo <= rx_data;
        P_YH:    y_hi <= rx_data[HI_W-1:0];
        P_YL:    y_lo <= rx_data;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                            idle_cnt <= '0;
    else if (rx_valid || p_state == P_XH || timeout || cmd_fc) idle_cnt <= '0;
    else                                                   idle_cnt <= idle_cnt + TO_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      ts <= '0;
    else if (cmd_fc) ts <= '0;
    else             ts <= ts + TS_W'(1);
  end

  // ------------------------------------------------------------ event FIFO
  logic [EVT_W-1:0] evt_mem [EVT_DEPTH];
  logic [EA-1:0]    evt_wr, evt_rd;
  logic [EL_W-1:0]  evt_level;
  logic             evt_empty, evt_full, evt_pop, evt_push, evt_drop;
  logic [EVT_W-1:0] evt_entry, evt_head;

  assign evt_empty = (evt_level == '0);
  assign evt_full  = (evt_level == EL_W'(EVT_DEPTH));
  assign evt_valid = !evt_empty;
  assign evt_pop   = evt_valid && evt_ready;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign evt_push  = evt_push_req && (!evt_full || evt_pop);
  assign evt_drop  = evt_push_req && evt_full && !evt_pop;
  assign evt_entry = {x_hi, x_lo, y_hi, y_lo, rx_data[0], ts};
  assign evt_head  = evt_mem[evt_rd];

  always_ff @(posedge clk) begin
    if (evt_push) evt_mem[evt_wr] <= evt_entry;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      evt_wr    <= '0;
      evt_rd    <= '0;
      evt_level <= '0;
    end else if (cmd_fc) begin
      evt_wr    <= '0;
      evt_rd    <= '0;
      evt_level <= '0;
    end else begin
      if (evt_push) evt_wr <= evt_wr + EA'(1);
      if (evt_pop)  evt_rd <= evt_rd + EA'(1);
      unique case ({evt_push, evt_pop})
        2'b10:   evt_level <= evt_level + EL_W'(1);
        2'b01:   evt_level <= evt_level - EL_W'(1);
        default: ;
      endcase
    end
  end

  // Storage is not reset, so the outputs are held at zero while empty.
  assign evt_x   = evt_valid ? evt_head[EVT_W-1 -: COORD_W]           : '0;
  assign evt_y   = evt_valid ? evt_head[TS_W+1+COORD_W-1 -: COORD_W]  : '0;
  assign evt_pol = evt_valid ? evt_head[TS_W]                         : 1'b0;
  assign evt_ts  = evt_valid ? evt_head[TS_W-1:0]                     : '0;

  // ---------------------------------------------------------- result queue
  logic [RES_W-1:0]   res_mem [RESP_DEPTH];
  logic [RA-1:0]      res_wr, res_rd;
  logic [RL_W-1:0]    res_level;
  logic               res_empty, res_full, res_pop, res_push, res_drop;
  logic [RES_W-1:0]   res_head;
  logic [CLASS_W-1:0] res_class;
  logic [CONF_W-1:0]  res_conf;

  t_state_t t_state, t_next;
  msg_t     msg, msg_next;

  assign res_empty = (res_level == '0);
  assign res_full  = (res_level == RL_W'(RESP_DEPTH));
  assign res_pop   = (t_state == T_B1) && (msg == M_RESULT) && !tx_busy;
  assign res_push  = gest_valid && (!res_full || res_pop);
  assign res_drop  = gest_valid && res_full && !res_pop;
  assign res_head  = res_mem[res_rd];
  assign res_class = res_head[RES_W-1 -: CLASS_W];
  assign res_conf  = res_head[CONF_W-1:0];

  always_ff @(posedge clk) begin
    if (res_push) res_mem[res_wr] <= {gest_class, gest_conf};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_wr    <= '0;
      res_rd    <= '0;
      res_level <= '0;
    end else if (cmd_fc) begin
      res_wr    <= '0;
      res_rd    <= '0;
      res_level <= '0;
    end else begin
      if (res_push) res_wr <= res_wr + RA'(1);
      if (res_pop)  res_rd <= res_rd + RA'(1);
      unique case ({res_push, res_pop})
        2'b10:   res_level <= res_level + RL_W'(1);
        2'b01:   res_level <= res_level - RL_W'(1);
        default: ;
      endcase
    end
  end

  // -------------------------------------------------- command slot, counters
  logic       cmd_pend;
  msg_t       cmd_msg;
  logic [7:0] drop_cnt, err_cnt;
  logic       stats_clear;
  logic [1:0] drop_inc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_pend <= 1'b0;
      cmd_msg  <= M_ECHO;
    end else if (cmd_fc) begin
      cmd_pend <= 1'b0;
    end else if (t_state == T_IDLE && cmd_pend) begin
      cmd_pend <= 1'b0;
    end else if (cmd_byte && !cmd_pend) begin
      cmd_pend <= 1'b1;
      cmd_msg  <= decode_cmd(rx_data);
    end
  end

  assign stats_clear = (t_state == T_B1) && (msg == M_STATS) && !tx_busy;
  assign drop_inc    = {1'b0, evt_drop} + {1'b0, res_drop};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt <= '0;
      err_cnt  <= '0;
    end else if (cmd_fc || stats_clear) begin
      drop_cnt <= '0;
      err_cnt  <= '0;
    end else begin
      drop_cnt <= sat_add(drop_cnt, drop_inc);
      err_cnt  <= sat_add(err_cnt, {1'b0, timeout});
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) soft_rst <= 1'b0;
    else        soft_rst <= cmd_fc;
  end

  // ---------------------------------------------------------------- TX FSM
  logic [7:0] byte0, byte1;

  always_comb begin
    byte0 = '0;
    byte1 = '0;
    unique case (msg)
      M_ECHO:   byte0 = 8'h55;
      M_STATUS: begin
        byte0 = {4'hB, acc_state, evt_empty};
        byte1 = 8'(evt_level);
      end
      M_CONFIG: begin
        byte0 = CFG0;
        byte1 = CFG1;
      end
      M_STATS: begin
        byte0 = drop_cnt;
        byte1 = err_cnt;
      end
      M_RESULT: begin
        byte0 = {4'hA, 4'(res_class)};
        byte1 = 8'(res_conf);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      t_state <= T_IDLE;
      msg     <= M_ECHO;
    end else if (cmd_fc) begin
      t_state <= T_IDLE;
    end else begin
      t_state <= t_next;
      msg     <= msg_next;
    end
  end

  always_comb begin
    t_next   = t_state;
    msg_next = msg;
    tx_valid = 1'b0;
    tx_data  = '0;
    unique case (t_state)
      T_IDLE: begin
        if (cmd_pend) begin
          msg_next = cmd_msg;
          t_next   = T_B0;
        end else if (!res_empty) begin
          msg_next = M_RESULT;
          t_next   = T_B0;
        end
      end
      T_B0: begin
        if (!tx_busy) begin
          tx_valid = 1'b1;
          tx_data  = byte0;
          t_next   = T_GAP0;
        end
      end
      T_GAP0:  t_next = (msg == M_ECHO) ? T_IDLE : T_B1;
      T_B1: begin
        if (!tx_busy) begin
          tx_valid = 1'b1;
          tx_data  = byte1;
          t_next   = T_GAP1;
        end
      end
      T_GAP1:  t_next = T_IDLE;
      default: t_next = T_IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_event_bridge.sv
module tb_uart_event_bridge;

  localparam int unsigned COORD_W      = 9;
  localparam int unsigned TS_W         = 16;
  localparam int unsigned EVT_DEPTH    = 8;
  localparam int unsigned RESP_DEPTH   = 4;
  localparam int unsigned CLASS_W      = 2;
  localparam int unsigned CONF_W       = 4;
  localparam int unsigned BYTE_TIMEOUT = 4096;
  localparam int unsigned HI_W         = COORD_W - 8;
  localparam int unsigned EVT_W        = 2 * COORD_W + 1 + TS_W;

  logic               clk = 1'b0;
  logic               rst_n;
  logic [7:0]         rx_data;
  logic               rx_valid;
  logic [7:0]         tx_data;
  logic               tx_valid;
  logic               tx_busy;
  logic               evt_valid;
  logic               evt_ready;
  logic [COORD_W-1:0] evt_x;
  logic [COORD_W-1:0] evt_y;
  logic               evt_pol;
  logic [TS_W-1:0]    evt_ts;
  logic               gest_valid;
  logic [CLASS_W-1:0] gest_class;
  logic [CONF_W-1:0]  gest_conf;
  logic [2:0]         acc_state;
  logic               soft_rst;

  always #5 clk = ~clk;

  uart_event_bridge #(
    .COORD_W(COORD_W), .TS_W(TS_W), .EVT_DEPTH(EVT_DEPTH), .RESP_DEPTH(RESP_DEPTH),
    .CLASS_W(CLASS_W), .CONF_W(CONF_W), .BYTE_TIMEOUT(BYTE_TIMEOUT),
    .CFG0(8'd20), .CFG1(8'd8)
  ) dut (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_busy(tx_busy),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_x(evt_x), .evt_y(evt_y),
    .evt_pol(evt_pol), .evt_ts(evt_ts), .gest_valid(gest_valid),
    .gest_class(gest_class), .gest_conf(gest_conf), .acc_state(acc_state),
    .soft_rst(soft_rst)
  );

  // Reference model: expected tx bytes and events in order, plus counters.
  int               checks = 0;
  int               errors = 0;
  logic [7:0]       exp_tx [$];
  logic [EVT_W-1:0] exp_evt [$];
  int unsigned      m_drop = 0;
  int unsigned      m_err  = 0;
  longint           ts_zero;    // time of the edge at which ts reads 0
  longint           last_edge;
  longint           last_ts;
  bit               rand_ready = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1 && tx_valid === 1'b1) begin
      chk("tx_while_busy", 64'(tx_busy), 64'd0);
      chk("tx_byte_expected", 64'(exp_tx.size() != 0), 64'd1);
      if (exp_tx.size() != 0) chk("tx_byte", 64'(tx_data), 64'(exp_tx.pop_front()));
    end
  end

  always @(negedge clk) begin
    if (rst_n === 1'b1 && evt_valid === 1'b1 && evt_ready === 1'b1) begin
      chk("evt_expected", 64'(exp_evt.size() != 0), 64'd1);
      if (exp_evt.size() != 0)
        chk("evt_fields", 64'({evt_x, evt_y, evt_pol, evt_ts}), 64'(exp_evt.pop_front()));
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    last_edge = $time;
    #1;
    if (rand_ready) evt_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
  endtask

  function automatic int unsigned sat_inc(input int unsigned v);
    return (v < 255) ? v + 1 : 255;
  endfunction

  // Sends one packet; the model stores the event at the POL byte.
  task automatic send_pkt(input logic [7:0] b0, b1, b2, b3, b4, input int max_gap);
    logic [7:0]  b [5];
    int unsigned x, y;
    b = '{b0, b1, b2, b3, b4};
    x = ((int'(b0) & ((1 << HI_W) - 1)) << 8) | int'(b1);
    y = ((int'(b2) & ((1 << HI_W) - 1)) << 8) | int'(b3);
    for (int i = 0; i < 5; i++) begin
      if (i == 4) begin
        last_ts = ((last_edge + 10 - ts_zero) / 10) % (longint'(1) << TS_W);
        if (exp_evt.size() < EVT_DEPTH)
          exp_evt.push_back({COORD_W'(x), COORD_W'(y), b4[0], TS_W'(last_ts)});
        else
          m_drop = sat_inc(m_drop);
      end
      send_byte(b[i]);
      if (i < 4 && max_gap > 0) ticks($urandom_range(0, max_gap));
    end
  endtask

  task automatic send_rand_pkt(input int max_gap);
    send_pkt(8'($urandom_range(0, 8'hF0)), 8'($urandom), 8'($urandom_range(0, 8'hF0)),
             8'($urandom), 8'($urandom), max_gap);
  endtask

  task automatic send_stats();
    exp_tx.push_back(8'(m_drop));
    exp_tx.push_back(8'(m_err));
    m_drop = 0;
    m_err  = 0;
    send_byte(8'hFB);
  endtask

  task automatic gest(input logic [CLASS_W-1:0] c, input logic [CONF_W-1:0] f);
    gest_valid = 1'b1;
    gest_class = c;
    gest_conf  = f;
    tick();
    gest_valid = 1'b0;
  endtask

  task automatic wait_tx(input int budget);
    for (int i = 0; i < budget && exp_tx.size() != 0; i++) tick();
    chk("tx_drain", 64'(exp_tx.size()), 64'd0);
    ticks(8);
  endtask

  task automatic wait_evt(input int budget);
    for (int i = 0; i < budget && exp_evt.size() != 0; i++) tick();
    chk("evt_drain", 64'(exp_evt.size()), 64'd0);
    tick();
    chk("evt_empty_after_drain", 64'(evt_valid), 64'd0);
  endtask

  initial begin
    rst_n = 1'b0; rx_data = '0; rx_valid = 1'b0; tx_busy = 1'b0; evt_ready = 1'b0;
    gest_valid = 1'b0; gest_class = '0; gest_conf = '0; acc_state = '0;
    ticks(2);
    chk("rst_tx_valid", 64'(tx_valid), 64'd0);
    chk("rst_tx_data", 64'(tx_data), 64'd0);
    chk("rst_evt_valid", 64'(evt_valid), 64'd0);
    chk("rst_evt_fields", 64'({evt_x, evt_y, evt_pol, evt_ts}), 64'd0);
    chk("rst_soft_rst", 64'(soft_rst), 64'd0);
    rst_n = 1'b1;
    ts_zero = last_edge + 10;
    ticks(3);

    // Single packet, sink ready: visible the cycle after the POL byte.
    evt_ready = 1'b1;
    send_pkt(8'h01, 8'h3F, 8'h00, 8'hA0, 8'h01, 0);
    chk("pkt_evt_valid", 64'(evt_valid), 64'd1);
    chk("pkt_evt_x", 64'(evt_x), 64'h13F);
    chk("pkt_evt_y", 64'(evt_y), 64'h0A0);
    chk("pkt_evt_pol", 64'(evt_pol), 64'd1);
    chk("pkt_evt_ts", 64'(evt_ts), 64'(last_ts));
    wait_evt(20);

    // Ten packets into a stalled sink: eight held, two dropped.
    evt_ready = 1'b0;
    for (int i = 0; i < 10; i++) send_rand_pkt(1);
    chk("full_evt_valid", 64'(evt_valid), 64'd1);
    send_stats();
    wait_tx(50);
    send_stats();
    wait_tx(50);
    acc_state = 3'b101;
    exp_tx.push_back({4'hB, acc_state, 1'(exp_evt.size() == 0)});
    exp_tx.push_back(8'(exp_evt.size()));
    send_byte(8'hFE);
    wait_tx(50);
    exp_tx.push_back(8'd20);
    exp_tx.push_back(8'd8);
    send_byte(8'hFD);
    wait_tx(50);
    evt_ready = 1'b1;
    wait_evt(100);

    // Partial packet, long idle: resync and count one error.
    send_byte(8'h01);
    send_byte(8'h3F);
    ticks(5000);
    m_err = sat_inc(m_err);
    send_pkt(8'h00, 8'h12, 8'h01, 8'h34, 8'h00, 0);
    wait_evt(20);
    send_stats();
    wait_tx(50);

    // Results queued while the transmitter is busy; the fifth overflows.
    tx_busy = 1'b1;
    exp_tx.push_back(8'hA3); exp_tx.push_back(8'h09);
    exp_tx.push_back(8'hA1); exp_tx.push_back(8'h02);
    exp_tx.push_back(8'hA0); exp_tx.push_back(8'h0F);
    exp_tx.push_back(8'hA2); exp_tx.push_back(8'h05);
    gest(2'd3, 4'd9);
    gest(2'd1, 4'd2);
    gest(2'd0, 4'd15);
    gest(2'd2, 4'd5);
    gest(2'd1, 4'd1);
    m_drop = sat_inc(m_drop);
    ticks(5);
    tx_busy = 1'b0;
    wait_tx(100);
    send_stats();
    wait_tx(50);

    // Echo during a result message, second command ignored while slot full.
    tx_busy = 1'b1;
    exp_tx.push_back(8'hA2); exp_tx.push_back(8'h07); exp_tx.push_back(8'h55);
    gest(2'd2, 4'd7);
    ticks(2);
    send_byte(8'hFF);
    send_byte(8'hFE);
    ticks(2);
    tx_busy = 1'b0;
    wait_tx(50);

    // Randomized bursts with a randomly stalling sink.
    for (int r = 0; r < 8; r++) begin
      int n;
      n = $urandom_range(1, 6);
      rand_ready = 1'b1;
      for (int p = 0; p < n; p++) begin
        ticks($urandom_range(0, 3));
        send_rand_pkt(2);
      end
      rand_ready = 1'b0;
      evt_ready  = 1'b1;
      wait_evt(200);
    end
    send_stats();
    wait_tx(50);

    // Soft reset with three events queued.
    evt_ready = 1'b0;
    for (int i = 0; i < 3; i++) send_rand_pkt(0);
    chk("pre_fc_evt_valid", 64'(evt_valid), 64'd1);
    send_byte(8'hFC);
    exp_evt.delete();
    m_drop  = 0;
    m_err   = 0;
    ts_zero = last_edge + 10;
    chk("fc_soft_rst_pulse", 64'(soft_rst), 64'd1);
    chk("fc_evt_flushed", 64'(evt_valid), 64'd0);
    tick();
    chk("fc_soft_rst_end", 64'(soft_rst), 64'd0);
    ticks(3);
    evt_ready = 1'b1;
    send_rand_pkt(0);
    chk("fc_ts_restart", 64'(evt_ts), 64'(last_ts));
    wait_evt(20);

    // Async reset in the middle of a message.
    tx_busy = 1'b1;
    send_byte(8'hFD);
    ticks(3);
    tx_busy = 1'b0;
    #1;
    chk("mid_tx_valid", 64'(tx_valid), 64'd1);
    chk("mid_tx_data", 64'(tx_data), 64'h14);
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_tx_valid", 64'(tx_valid), 64'd0);
    chk("arst_soft_rst", 64'(soft_rst), 64'd0);
    ticks(2);
    rst_n = 1'b1;
    ts_zero = last_edge + 10;
    exp_evt.delete();
    exp_tx.delete();
    m_drop = 0;
    m_err  = 0;
    ticks(2);
    send_stats();
    wait_tx(50);
    send_rand_pkt(1);
    wait_evt(20);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
